// File: rtl/mem_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_pkg: shared types, constants and byte-lane helpers for memory ports    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
package mem_pkg;

  typedef logic master_idx_t;

  localparam int NUM_MASTERS = 2;

  // One byte lane of a byte-enable merge; callers replicate it per lane.
  function automatic logic [7:0] merge_bytes(
    input logic       sel,
    input logic [7:0] new_byte,
    input logic [7:0] old_byte
  );
    return sel ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin arbiter for one request class             |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic        advance,
  output logic [1:0]  gnt,
  output master_idx_t rr_ptr
);

  master_idx_t r_ptr;

  // The winner is always r_ptr, so handing priority to the loser is a toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= ~r_ptr;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  assign rr_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_port_arbiter: two-master OBI-style arbiter in front of a 1W/1R RAM     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 10,
  localparam int BAW        = ADDR_WIDTH + $clog2(DATA_WIDTH / 8)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 m_req,
  input  logic [1:0]                 m_we,
  input  logic [1:0][BAW-1:0]        m_addr,
  input  logic [1:0][DATA_WIDTH/8-1:0] m_be,
  input  logic [1:0][DATA_WIDTH-1:0] m_wdata,
  output logic [1:0]                 m_gnt,
  output logic [1:0]                 m_rvalid,
  output logic [1:0][DATA_WIDTH-1:0] m_rdata,
  output logic                       ram_wr_en,
  output logic [ADDR_WIDTH-1:0]      ram_wr_addr,
  output logic [DATA_WIDTH-1:0]      ram_wr_data,
  output logic [DATA_WIDTH/8-1:0]    ram_wr_be,
  output logic [ADDR_WIDTH-1:0]      ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]      ram_rd_data
);

  localparam int c_NB  = DATA_WIDTH / 8;
  localparam int c_OFS = $clog2(c_NB);

  logic [1:0]            w_wr_req, w_rd_req, w_arb_req, w_arb_gnt;
  logic [1:0]            w_wr_gnt, w_rd_gnt;
  logic                  w_wr_cont, w_rd_cont, w_wr_any, w_rd_any, w_fwd_hit;
  master_idx_t           w_ptr, w_wr_idx, w_rd_idx;
  logic [ADDR_WIDTH-1:0] w_wr_word, w_rd_word;
  logic [1:0][DATA_WIDTH-1:0] w_rd_merged;

  logic [1:0]            r_pend_valid, r_pend_is_rd, r_fwd_match;
  logic [c_NB-1:0]       r_fwd_be;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  assign w_wr_req  = rst ? 2'b00 : (m_req &  m_we);
  assign w_rd_req  = rst ? 2'b00 : (m_req & ~m_we);
  assign w_wr_cont = &w_wr_req;
  assign w_rd_cont = &w_rd_req;

  // With two masters at most one class can be contended in a given cycle.
  assign w_arb_req = w_wr_cont ? w_wr_req : (w_rd_cont ? w_rd_req : 2'b00);

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .rst     (rst),
    .req     (w_arb_req),
    .advance (w_wr_cont | w_rd_cont),
    .gnt     (w_arb_gnt),
    .rr_ptr  (w_ptr)
  );

  assign w_wr_gnt = w_wr_cont ? w_arb_gnt : w_wr_req;
  assign w_rd_gnt = w_rd_cont ? w_arb_gnt : w_rd_req;
  assign w_wr_any = |w_wr_gnt;
  assign w_rd_any = |w_rd_gnt;
  assign w_wr_idx = w_wr_cont ? w_ptr : w_wr_req[1];
  assign w_rd_idx = w_rd_cont ? w_ptr : w_rd_req[1];
  assign m_gnt    = w_wr_gnt | w_rd_gnt;

  assign w_wr_word = m_addr[w_wr_idx][BAW-1:c_OFS];
  assign w_rd_word = m_addr[w_rd_idx][BAW-1:c_OFS];

  assign ram_wr_en   = w_wr_any;
  assign ram_wr_addr = w_wr_any ? w_wr_word         : '0;
  assign ram_wr_data = w_wr_any ? m_wdata[w_wr_idx] : '0;
  assign ram_wr_be   = w_wr_any ? m_be[w_wr_idx]    : '0;
  assign ram_rd_addr = w_rd_any ? w_rd_word         : '0;

  // The RAM is read-first, so same-word collisions are patched from the write.
  assign w_fwd_hit = w_wr_any & w_rd_any & (w_wr_word == w_rd_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 2'b00;
      r_pend_is_rd <= 2'b00;
      r_fwd_match  <= 2'b00;
      r_fwd_be     <= '0;
      r_fwd_data   <= '0;
    end else begin
      r_pend_valid <= m_gnt;
      r_pend_is_rd <= w_rd_gnt;
      r_fwd_match  <= w_fwd_hit ? w_rd_gnt : 2'b00;
      r_fwd_be     <= w_fwd_hit ? ram_wr_be : '0;
      r_fwd_data   <= w_fwd_hit ? ram_wr_data : '0;
    end
  end

  assign m_rvalid = rst ? 2'b00 : r_pend_valid;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    for (genvar b = 0; b < c_NB; b++) begin : g_lane
      assign w_rd_merged[i][b*8 +: 8] = merge_bytes(r_fwd_match[i] & r_fwd_be[b],
                                                    r_fwd_data[b*8 +: 8],
                                                    ram_rd_data[b*8 +: 8]);
    end
    assign m_rdata[i] = (m_rvalid[i] & r_pend_is_rd[i]) ? w_rd_merged[i] : '0;
  end

  if (c_OFS > 0) begin : g_addr_lsbs
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{m_addr[0][c_OFS-1:0], m_addr[1][c_OFS-1:0]};
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed + random bench with a transaction-level model|
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int BAW = 6;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]          m_req, m_we, m_gnt, m_rvalid;
  logic [1:0][BAW-1:0] m_addr;
  logic [1:0][3:0]     m_be;
  logic [1:0][DW-1:0]  m_wdata, m_rdata;
  logic                ram_wr_en;
  logic [AW-1:0]       ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]       ram_wr_data, ram_rd_data;
  logic [3:0]          ram_wr_be;

  logic [DW-1:0] ram [16];

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_be(ram_wr_be), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // Read-first RAM with registered output, as generic_ram behaves.
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_be[b]) ram[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    ram_rd_data <= ram[ram_rd_addr];
  end

  // Transaction-level model: memory image, priority owner, outstanding replies.
  logic [DW-1:0]      mdl_mem [16];
  logic               mdl_ptr = 1'b0;
  logic [1:0]         mdl_pend = 2'b00;
  logic [1:0][DW-1:0] mdl_resp = '0;

  logic [1:0]         last_gnt, last_rvalid;
  logic [1:0][DW-1:0] last_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [1:0] wr, rd, eg_w, eg_r;
    logic [1:0][DW-1:0] nxt;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] v;
    int wi, ri;
    @(negedge clk);
    wr = m_req & m_we;
    rd = m_req & ~m_we;
    eg_w = (wr == 2'b11) ? (mdl_ptr ? 2'b10 : 2'b01) : wr;
    eg_r = (rd == 2'b11) ? (mdl_ptr ? 2'b10 : 2'b01) : rd;
    if (rst) begin eg_w = 2'b00; eg_r = 2'b00; end
    wi = int'(eg_w[1]);
    ri = int'(eg_r[1]);
    wa = m_addr[wi][5:2];
    ra = m_addr[ri][5:2];
    chk("gnt", 32'(m_gnt), 32'(eg_w | eg_r));
    chk("rvalid", 32'(m_rvalid), rst ? 32'h0 : 32'(mdl_pend));
    for (int i = 0; i < 2; i++)
      chk($sformatf("rdata%0d", i), m_rdata[i], (!rst && mdl_pend[i]) ? mdl_resp[i] : 32'h0);
    chk("wr_en",   32'(ram_wr_en),   32'(|eg_w));
    chk("wr_addr", 32'(ram_wr_addr), (|eg_w) ? 32'(wa) : 32'h0);
    chk("wr_data", ram_wr_data,      (|eg_w) ? m_wdata[wi] : 32'h0);
    chk("wr_be",   32'(ram_wr_be),   (|eg_w) ? 32'(m_be[wi]) : 32'h0);
    chk("rd_addr", 32'(ram_rd_addr), (|eg_r) ? 32'(ra) : 32'h0);
    nxt = '0;
    if (|eg_r) begin
      v = mdl_mem[ra];
      if ((|eg_w) && wa == ra)
        for (int b = 0; b < 4; b++) if (m_be[wi][b]) v[b*8 +: 8] = m_wdata[wi][b*8 +: 8];
      nxt[ri] = v;
    end
    last_gnt    = m_gnt;
    last_rvalid = m_rvalid;
    last_rdata  = m_rdata;
    @(posedge clk);
    if (|eg_w)
      for (int b = 0; b < 4; b++) if (m_be[wi][b]) mdl_mem[wa][b*8 +: 8] = m_wdata[wi][b*8 +: 8];
    mdl_pend = eg_w | eg_r;
    mdl_resp = nxt;
    if (rst) mdl_ptr = 1'b0;
    else if (wr == 2'b11 || rd == 2'b11) mdl_ptr = ~mdl_ptr;
    #1;
  endtask

  task automatic set_m(input int i, input logic rq, input logic we, input logic [5:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    m_req[i] = rq; m_we[i] = we; m_addr[i] = a; m_be[i] = be; m_wdata[i] = d;
  endtask

  task automatic idle();
    set_m(0, 1'b0, 1'b0, 6'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 6'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    logic [1:0]  ww_exp [4];
    ww_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1;
    idle();
    repeat (2) step();
    chk("reset_gnt", 32'(last_gnt), 32'h0);
    chk("reset_rvalid", 32'(last_rvalid), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      val = (k == 1) ? 32'h12345678 : (k == 2) ? 32'h11223344 :
            (k == 7) ? 32'hAABBCCDD : {4{8'(k * 17)}};
      set_m(0, 1'b1, 1'b1, 6'(k * 4), 4'hF, val);
      step();
    end
    idle(); step();

    // single write then read of word 5
    set_m(0, 1'b1, 1'b1, 6'h14, 4'hF, 32'hDEADBEEF); step();
    chk("wr_gnt", 32'(last_gnt), 32'h1);
    set_m(0, 1'b1, 1'b0, 6'h14, 4'h0, 32'h0); step();
    chk("wr_ack", 32'(last_rvalid), 32'h1);
    idle(); step();
    chk("rd_valid", 32'(last_rvalid), 32'h1);
    chk("rd_data", last_rdata[0], 32'hDEADBEEF);

    // write/write contention after reset
    rst = 1'b1; step(); rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 6'h20, 4'hF, 32'hA0A00000);
    set_m(1, 1'b1, 1'b1, 6'h24, 4'hF, 32'hB0B00000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("ww_gnt%0d", k), 32'(last_gnt), 32'(ww_exp[k]));
    end
    idle(); step();
    chk("ww_last_ack", 32'(last_rvalid), 32'h2);

    // read and write to different words together
    set_m(0, 1'b1, 1'b0, 6'h08, 4'h0, 32'h0);
    set_m(1, 1'b1, 1'b1, 6'h0C, 4'hF, 32'h0C0C0C0C);
    step();
    chk("rw_gnt", 32'(last_gnt), 32'h3);
    idle(); step();
    chk("rw_rvalid", 32'(last_rvalid), 32'h3);
    chk("rw_rdata", last_rdata[0], 32'h11223344);

    // same-cycle collision on word 7
    set_m(1, 1'b1, 1'b1, 6'h1C, 4'h5, 32'h55667788);
    set_m(0, 1'b1, 1'b0, 6'h1C, 4'h0, 32'h0);
    step();
    idle(); step();
    chk("fwd_rdata", last_rdata[0], 32'hAA66CC88);

    // reset mid-transaction, with priority moved to master 1 beforehand
    set_m(0, 1'b1, 1'b1, 6'h28, 4'hF, 32'h1);
    set_m(1, 1'b1, 1'b1, 6'h2C, 4'hF, 32'h2);
    step();
    set_m(0, 1'b1, 1'b0, 6'h08, 4'h0, 32'h0);
    step();
    chk("pre_rst_gnt", 32'(last_gnt), 32'h3);
    rst = 1'b1;
    set_m(0, 1'b1, 1'b1, 6'h30, 4'hF, 32'h3);
    step();
    chk("in_rst_gnt", 32'(last_gnt), 32'h0);
    chk("in_rst_rvalid", 32'(last_rvalid), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_gnt", 32'(last_gnt), 32'h1);
    idle(); step();

    // zero byte-enable write to word 1
    set_m(0, 1'b1, 1'b1, 6'h04, 4'h0, 32'hFFFFFFFF); step();
    chk("be0_gnt", 32'(last_gnt), 32'h1);
    set_m(0, 1'b1, 1'b0, 6'h04, 4'h0, 32'h0); step();
    chk("be0_ack", 32'(last_rvalid), 32'h1);
    chk("be0_ack_data", last_rdata[0], 32'h0);
    idle(); step();
    chk("be0_rdata", last_rdata[0], 32'h12345678);

    // random traffic; requests held until granted
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_req[i] || last_gnt[i]) begin
          set_m(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 31)), 4'($urandom), $urandom);
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
